if_prefetch_queue: RTL and testbench

//  Instruction-fetch front end sitting directly upstream of the cpu's IR pipeline.

---
 rtl/if_prefetch_queue_pkg.sv | 19 +
 rtl/if_prefetch_queue_fifo.sv | 73 +++++++
 rtl/if_prefetch_queue.sv | 158 +++++++++++++++
 tb/tb_if_prefetch_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   ifq_state_e : fetch-control FSM state encodings (BOOT / RUN / HALT)
//   PC_STEP     : byte distance between consecutive instruction words
//   word_align  : clears the byte-offset bits of a fetch address
package if_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    IFQ_BOOT = 2'd0,
    IFQ_RUN  = 2'd1,
    IFQ_HALT = 2'd2
  } ifq_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer holding {pc, instruction} pairs.
// Ports:
//   clock, reset    : clock and synchronous active-high reset
//   flush           : empties the buffer next cycle (overrides push/pop)
//   push, push_data : write one entry at the tail
//   pop             : remove the head entry (ignored when empty)
//   head_data       : entry at the head (meaningless when empty)
//   count, empty    : current occupancy
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // A flush wins over everything; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_ok  = push & ~flush;
    pop_ok   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end feeding decode.
// Issues in-order word fetches, buffers returned words with their PCs, presents
// them over valid/ready and discards stale responses after a redirect.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   redirect, redirect_pc    : flush and restart fetch at redirect_pc (word aligned)
//   halt                     : stop issuing new fetches; queue still drains
//   imem_req/addr/gnt        : request channel to instruction memory
//   imem_rvalid/rdata        : in-order response channel
//   out_valid/ready/inst/pc  : instruction stream to decode
//   level                    : queue occupancy
// Build option: define IFQ_BYPASS_EN to forward a response straight to out_*
// in the same cycle when the queue is empty and decode is ready.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int                CNT_W     = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUTST);

  ifq_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [63:0]      fifo_head;
  logic             req_fire, rsp_ok, rsp_keep, bypass_take, fifo_push, fifo_pop;

  // Credit rule: queued words plus in-flight fetches never exceed DEPTH, so a
  // response always has a slot to land in.
  always_comb begin
    imem_req = 1'b0;
    if (!reset && state_q == IFQ_RUN && !redirect &&
        (({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_C) &&
        (outst_q < MAX_OUT_C))
      imem_req = 1'b1;
  end

  assign imem_addr = fetch_pc_q;
  assign req_fire  = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok    = imem_rvalid & ~reset & (outst_q != '0);
  assign rsp_keep  = rsp_ok & (drop_cnt_q == '0) & ~redirect;

`ifdef IFQ_BYPASS_EN
  assign bypass_take = rsp_keep & fifo_empty & out_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign fifo_push = rsp_keep & ~bypass_take;
  assign fifo_pop  = ~fifo_empty & out_ready & ~reset;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data ({resp_pc_q, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Output stage: the bypassed response takes the port only when storage is empty.
  always_comb begin
    out_valid = 1'b0;
    out_inst  = '0;
    out_pc    = '0;
    if (!reset) begin
      if (bypass_take) begin
        out_valid = 1'b1;
        out_inst  = imem_rdata;
        out_pc    = resp_pc_q;
      end else if (!fifo_empty) begin
        out_valid = 1'b1;
        out_pc    = fifo_head[63:32];
        out_inst  = fifo_head[31:0];
      end
    end
  end

  assign level = reset ? '0 : fifo_count;

  // Next-state for FSM, PCs and counters. Redirect overrides the normal PC and
  // drop updates; every fetch still in flight after this cycle becomes stale.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IFQ_BOOT: state_d = IFQ_RUN;
      IFQ_RUN:  if (halt)  state_d = IFQ_HALT;
      IFQ_HALT: if (!halt) state_d = IFQ_RUN;
      default:  state_d = IFQ_BOOT;
    endcase

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);

    if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;

    if (rsp_ok && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    else if (rsp_keep)              resp_pc_d  = resp_pc_q + PC_STEP;

    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_cnt_d = outst_d;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IFQ_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue: an in-order memory model answers granted
// fetches one cycle later; a scoreboard of expected {pc, inst} pairs is filled
// from the bench's own PC model as responses are driven and drained as decode
// accepts words.
module tb_if_prefetch_queue;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          LVL_W     = $clog2(DEPTH+1);
  localparam int          FREE      = 100000;

  logic             clock = 1'b0;
  logic             reset;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             halt;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [LVL_W-1:0] level;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] sb[$];
  logic [31:0] mem_q[$];
  logic [31:0] ghost_q[$];
  int          stale        = 0;
  int          rsp_budget   = FREE;
  int          cur_rsp      = 0;
  int          grants       = 0;
  logic [31:0] exp_fetch_pc = RESET_PC;
  logic [31:0] exp_resp_pc  = RESET_PC;

  always #5 clock = ~clock;

  if_prefetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .level       (level)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // One clock cycle: observe at the negedge what the coming edge will do,
  // update the reference model, then drive the memory response for the next cycle.
  task automatic tick();
    logic [63:0] e;
    @(negedge clock);
    if (reset) begin
      sb.delete();
      foreach (mem_q[i]) ghost_q.push_back(mem_q[i]);
      mem_q.delete();
      stale        = 0;
      exp_fetch_pc = RESET_PC;
      exp_resp_pc  = RESET_PC;
    end else begin
      if (cur_rsp == 1 && !redirect) begin
        if (stale > 0) stale--;
        else begin
          sb.push_back({exp_resp_pc, inst_of(exp_resp_pc)});
          exp_resp_pc += 32'd4;
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL out_unexpected: got pc=%h inst=%h expected no output", out_pc, out_inst);
        end else begin
          e = sb.pop_front();
          if ({out_pc, out_inst} !== e) begin
            tests_failed++;
            $display("[TB] FAIL out_stream: got pc=%h inst=%h expected pc=%h inst=%h",
                     out_pc, out_inst, e[63:32], e[31:0]);
          end
        end
      end
      if (imem_req && imem_gnt) begin
        tests_run++;
        if (imem_addr !== exp_fetch_pc) begin
          tests_failed++;
          $display("[TB] FAIL fetch_addr: got %h expected %h", imem_addr, exp_fetch_pc);
        end
        mem_q.push_back(imem_addr);
        exp_fetch_pc += 32'd4;
        grants++;
      end
      if (redirect) begin
        sb.delete();
        stale        = mem_q.size();
        exp_fetch_pc = redirect_pc & ~32'h3;
        exp_resp_pc  = redirect_pc & ~32'h3;
      end
    end
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cur_rsp     = 0;
    if (rsp_budget > 0) begin
      if (ghost_q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(ghost_q.pop_front());
        cur_rsp     = 2;
        rsp_budget--;
      end else if (mem_q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(mem_q.pop_front());
        cur_rsp     = 1;
        rsp_budget--;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; halt = 1'b0;
    out_ready = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (level !== '0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    tests_run++;
    if ({out_pc, out_inst} !== 64'h0) begin
      tests_failed++; $display("[TB] FAIL reset_out: got pc=%h inst=%h expected 0/0", out_pc, out_inst);
    end
    redirect = 1'b0;
    reset    = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL boot_req: got %b expected 0", imem_req); end
    tick();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      tests_failed++; $display("[TB] FAIL first_req: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 1) begin
        tests_run++;
        if (out_valid !== 1'b1) begin
          tests_failed++; $display("[TB] FAIL stream_gap: cycle %0d got out_valid=%b expected 1", i, out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int g0;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    tests_run++;
    if (level !== LVL_W'(4)) begin tests_failed++; $display("[TB] FAIL full_level: got %0d expected 4", level); end
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_req: got %b expected 0", imem_req); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL refill_req: got %b expected 1", imem_req); end
    g0 = grants;
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (grants - g0 != 1) begin tests_failed++; $display("[TB] FAIL refill_grants: got %0d expected 1", grants - g0); end
    tests_run++;
    if (level !== LVL_W'(4)) begin tests_failed++; $display("[TB] FAIL refill_level: got %0d expected 4", level); end
    out_ready = 1'b1;
  endtask

  task automatic test_redirect();
    bit found;
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rsp_budget = 0;
    imem_gnt   = 1'b1;
    do_redirect(32'h10);
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL outst_limit_req: got %b expected 0", imem_req); end
    do_redirect(32'h103);
    rsp_budget = FREE;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (out_valid) found = 1;
      else tick();
    end
    tests_run++;
    if (!found || out_pc !== 32'h100) begin
      tests_failed++; $display("[TB] FAIL redirect_first_pc: got valid=%b pc=%h expected 1/00000100", out_valid, out_pc);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_back_to_back();
    bit found;
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect    = 1'b0;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (out_valid) found = 1;
      else tick();
    end
    tests_run++;
    if (!found || out_pc !== 32'hFFFF_FFF8) begin
      tests_failed++; $display("[TB] FAIL b2b_first_pc: got valid=%b pc=%h expected 1/fffffff8", out_valid, out_pc);
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_halt();
    int g0;
    out_ready  = 1'b0;
    rsp_budget = 0;
    do_redirect(32'h400);
    for (int i = 0; i < 3; i++) tick();
    halt = 1'b1;
    g0   = grants;
    for (int i = 0; i < 3; i++) tick();
    rsp_budget = FREE;
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (level !== LVL_W'(2)) begin tests_failed++; $display("[TB] FAIL halt_level: got %0d expected 2", level); end
    tests_run++;
    if (imem_req !== 1'b0 || grants != g0) begin
      tests_failed++; $display("[TB] FAIL halt_noreq: got req=%b grants=%0d expected 0/0", imem_req, grants - g0);
    end
    halt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (grants == g0) begin tests_failed++; $display("[TB] FAIL halt_resume: got %0d grants expected >0", grants - g0); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_midstream();
    bit found;
    out_ready  = 1'b0;
    rsp_budget = 0;
    do_redirect(32'h800);
    for (int i = 0; i < 3; i++) tick();
    rsp_budget = 2;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (level !== LVL_W'(2) || imem_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL mid_pre: got level=%0d req=%b expected 2/0", level, imem_req);
    end
    reset      = 1'b1;
    rsp_budget = FREE;
    tick();
    reset = 1'b0;
    tests_run++;
    if (level !== '0 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got level=%0d valid=%b req=%b expected 0/0/0", level, out_valid, imem_req);
    end
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (out_valid) found = 1;
      else tick();
    end
    tests_run++;
    if (!found || out_pc !== RESET_PC) begin
      tests_failed++; $display("[TB] FAIL mid_first_pc: got valid=%b pc=%h expected 1/%h", out_valid, out_pc, RESET_PC);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_bypass();
    out_ready  = 1'b1;
    rsp_budget = 0;
    do_redirect(32'hC00);
    for (int i = 0; i < 3; i++) tick();
    rsp_budget = 1;
    tick();
`ifdef IFQ_BYPASS_EN
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC00 || level !== '0) begin
      tests_failed++; $display("[TB] FAIL bypass_same: got valid=%b pc=%h level=%0d expected 1/c00/0", out_valid, out_pc, level);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || level !== '0) begin
      tests_failed++; $display("[TB] FAIL bypass_next: got valid=%b level=%0d expected 0/0", out_valid, level);
    end
`else
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL latency_same: got valid=%b expected 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC00 || level !== LVL_W'(1)) begin
      tests_failed++; $display("[TB] FAIL latency_next: got valid=%b pc=%h level=%0d expected 1/c00/1", out_valid, out_pc, level);
    end
`endif
    rsp_budget = FREE;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_drain();
    imem_gnt  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (sb.size() != 0 || level !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got pending=%0d level=%0d valid=%b expected 0/0/0", sb.size(), level, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_halt();
    test_reset_midstream();
    test_bypass();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
